// File: rtl/saph_pixel_writer_pkg.sv
// Shared types and helpers for the pixel writer.
//   saph_pixel_t     : rasterized pixel (signed 16-bit x/y, four signed 8.8 channels)
//   saph_fb_fmt_e    : framebuffer pixel format
//   saph_fb_wr_t     : one single-beat framebuffer write {addr, wdata, wstrb}
//   saph_sat8        : 8.8 channel to 8-bit saturate
//   saph_pack_colour : channel convert + pack into the 32-bit write data
package saph_pixel_writer_pkg;

  localparam int unsigned ColR = 0;
  localparam int unsigned ColG = 1;
  localparam int unsigned ColB = 2;
  localparam int unsigned ColA = 3;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [3:0][15:0]   col;  // indexed by ColR/ColG/ColB/ColA, signed 8.8
  } saph_pixel_t;

  typedef enum logic {
    SAPH_FB_ARGB8888 = 1'b0,
    SAPH_FB_RGB565   = 1'b1
  } saph_fb_fmt_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } saph_fb_wr_t;

  // Negative clamps to 0, anything at or above 1.0 clamps to 0xFF.
  function automatic logic [7:0] saph_sat8(input logic [15:0] v);
    logic [7:0] c;
    if (v[15]) begin
      c = 8'h00;
    end else if (v[14:8] != 7'd0) begin
      c = 8'hFF;
    end else begin
      c = v[7:0];
    end
    return c;
  endfunction

  // RGB565 is replicated into both halves so either strobe pattern picks it up.
  function automatic logic [31:0] saph_pack_colour(input logic [3:0][15:0] col,
                                                   input saph_fb_fmt_e fmt);
    logic [7:0]  r, g, b, a;
    logic [15:0] p;
    logic [31:0] d;
    r = saph_sat8(col[ColR]);
    g = saph_sat8(col[ColG]);
    b = saph_sat8(col[ColB]);
    a = saph_sat8(col[ColA]);
    p = {r[7:3], g[7:2], b[7:3]};
    if (fmt == SAPH_FB_RGB565) begin
      d = {p, p};
    end else begin
      d = {a, r, g, b};
    end
    return d;
  endfunction

endpackage

// File: rtl/saph_pixel_writer_if.sv
// Pixel-in handshake (trig/ready) and memory-write bus of the pixel writer.
//   slave  : the pixel writer (consumes pixels, drives write requests)
//   master : the upstream rasterizer / downstream arbiter side
interface saph_pixel_writer_if;
  import saph_pixel_writer_pkg::*;

  logic        in_trig;
  saph_pixel_t in_pixel;
  logic        in_ready;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  modport slave (
    input  in_trig, in_pixel, mem_ready,
    output in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output in_trig, in_pixel, mem_ready,
    input  in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/saph_fifo.sv
// Generic synchronous FIFO, any element type, power-of-two depth.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes contents)
//   push_i/wdata_i: write; accepted when not full, or when full and popping
//   pop_i         : read; ignored when empty (no write-to-read bypass)
//   rdata_o       : head entry (storage is reset to zero)
//   empty_o       : no entries
//   count_o       : number of entries, 0..Depth
module saph_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  T                             wdata_i,
  input  logic                         pop_i,
  output T                             rdata_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/saph_pixel_writer.sv
// Pixel write stage: clip, colour convert, address generation, buffered memory writes.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   bus            : pixel trig/ready input and single-beat write request output
//   cfg_base_i     : framebuffer byte base (4-byte aligned)
//   cfg_stride_i   : row pitch in bytes (multiple of 4)
//   cfg_width_i    : clip width, unsigned
//   cfg_height_i   : clip height, unsigned
//   cfg_fmt_i      : 0 = ARGB8888, 1 = RGB565
//   busy_o         : any pixel in S1, S2 or the FIFO
//   discard_cnt_o  : saturating count of clipped pixels
module saph_pixel_writer
  import saph_pixel_writer_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  saph_pixel_writer_if.slave      bus,
  input  logic [31:0]             cfg_base_i,
  input  logic [15:0]             cfg_stride_i,
  input  logic [15:0]             cfg_width_i,
  input  logic [15:0]             cfg_height_i,
  input  logic                    cfg_fmt_i,
  output logic                    busy_o,
  output logic [15:0]             discard_cnt_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  saph_fb_fmt_e    fmt;
  logic            accept, pop;
  logic [31:0]     occupancy;

  logic            s1_valid_q;
  saph_pixel_t     s1_pix_q;
  logic            s1_clip, s1_keep;

  logic            s2_valid_q;
  logic [15:0]     s2_x_q, s2_y_q;
  logic [31:0]     s2_data_q;
  logic [31:0]     y_off, x_off, byte_addr;
  saph_fb_wr_t     s2_wr, head;

  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;

  logic [15:0]     discard_cnt_q, discard_cnt_d;
  logic            unused_byte0;

  assign fmt = saph_fb_fmt_e'(cfg_fmt_i);

  // Credits cover every slot downstream, so S1/S2 never need to stall.
  assign occupancy    = 32'(s1_valid_q) + 32'(s2_valid_q) + 32'(fifo_count);
  assign bus.in_ready = (occupancy < FifoDepth);
  assign accept       = bus.in_trig && bus.in_ready;

  // S1: clip against the framebuffer rectangle.
  assign s1_clip = s1_pix_q.x[15] || s1_pix_q.y[15] ||
                   (s1_pix_q.x[15:0] >= cfg_width_i) ||
                   (s1_pix_q.y[15:0] >= cfg_height_i);
  assign s1_keep = s1_valid_q && !s1_clip;

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (s1_valid_q && s1_clip && (discard_cnt_q != 16'hFFFF)) begin
      discard_cnt_d = discard_cnt_q + 16'd1;
    end
  end

  // S2: byte address and strobes.
  assign y_off     = 32'(s2_y_q) * 32'(cfg_stride_i);
  assign x_off     = (fmt == SAPH_FB_RGB565) ? {15'd0, s2_x_q, 1'b0} : {14'd0, s2_x_q, 2'b00};
  assign byte_addr = cfg_base_i + y_off + x_off;
  assign unused_byte0 = byte_addr[0];

  always_comb begin
    s2_wr.addr  = {byte_addr[31:2], 2'b00};
    s2_wr.wdata = s2_data_q;
    if (fmt == SAPH_FB_RGB565) begin
      s2_wr.wstrb = byte_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      s2_wr.wstrb = 4'b1111;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q    <= 1'b0;
      s1_pix_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_x_q        <= '0;
      s2_y_q        <= '0;
      s2_data_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_pix_q <= bus.in_pixel;
      end
      s2_valid_q <= s1_keep;
      if (s1_keep) begin
        s2_x_q    <= s1_pix_q.x[15:0];
        s2_y_q    <= s1_pix_q.y[15:0];
        s2_data_q <= saph_pack_colour(s1_pix_q.col, fmt);
      end
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign pop = bus.mem_req && bus.mem_ready;

  saph_fifo #(
    .T     (saph_fb_wr_t),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (s2_valid_q),
    .wdata_i (s2_wr),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // FIFO count is reset asynchronously, so mem_req drops with reset.
  assign bus.mem_req   = !fifo_empty;
  assign bus.mem_addr  = head.addr;
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_wstrb = head.wstrb;

  assign busy_o        = s1_valid_q || s2_valid_q || !fifo_empty;
  assign discard_cnt_o = discard_cnt_q;

endmodule

// File: tb/tb_saph_pixel_writer.sv
// Self-checking bench for saph_pixel_writer: directed vector table, hand sequences for
// back-pressure and mid-operation reset, and randomized traffic against a reference model.
module tb_saph_pixel_writer;
  import saph_pixel_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_stride = '0, cfg_width = '0, cfg_height = '0;
  logic        cfg_fmt = 1'b0;
  logic        busy;
  logic [15:0] discard_cnt;

  saph_pixel_writer_if bus ();

  saph_pixel_writer #(
    .FifoDepth (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .cfg_base_i    (cfg_base),
    .cfg_stride_i  (cfg_stride),
    .cfg_width_i   (cfg_width),
    .cfg_height_i  (cfg_height),
    .cfg_fmt_i     (cfg_fmt),
    .busy_o        (busy),
    .discard_cnt_o (discard_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  wr_t exp_q[$];
  int  model_disc = 0;

  function automatic int chan8(input logic [15:0] v16);
    int v;
    v = $signed(v16);
    if (v < 0) return 0;
    if (v >= 256) return 255;
    return v;
  endfunction

  function automatic bit model_clip(input saph_pixel_t p);
    int xi, yi;
    xi = p.x;
    yi = p.y;
    return (xi < 0) || (yi < 0) || (xi >= int'(cfg_width)) || (yi >= int'(cfg_height));
  endfunction

  function automatic wr_t model_write(input saph_pixel_t p);
    wr_t w;
    longint unsigned b, bpp, xu, yu, st, bs;
    int r, g, bl, a, p16;
    r  = chan8(p.col[0]);
    g  = chan8(p.col[1]);
    bl = chan8(p.col[2]);
    a  = chan8(p.col[3]);
    bpp = cfg_fmt ? 2 : 4;
    xu = p.x[15:0];
    yu = p.y[15:0];
    st = cfg_stride;
    bs = cfg_base;
    b  = (bs + yu * st + xu * bpp) % 64'h1_0000_0000;
    w.addr = 32'(b - (b % 4));
    if (!cfg_fmt) begin
      w.wdata = 32'(a * 16777216 + r * 65536 + g * 256 + bl);
      w.wstrb = 4'hF;
    end else begin
      p16 = (r / 8) * 2048 + (g / 4) * 32 + (bl / 8);
      w.wdata = 32'(p16 * 65536 + p16);
      w.wstrb = ((b / 2) % 2 == 1) ? 4'hC : 4'h3;
    end
    return w;
  endfunction

  // Monitor: scoreboard on accepted pixels / completed writes, plus hold-while-stalled check.
  int          wr_seen = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_addr, hold_data;

  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_req", bus.mem_req, 1'b1);
        chk("hold_addr", bus.mem_addr, hold_addr);
        chk("hold_wdata", bus.mem_wdata, hold_data);
      end
      hold_v    = bus.mem_req && !bus.mem_ready;
      hold_addr = bus.mem_addr;
      hold_data = bus.mem_wdata;
      if (bus.in_trig && bus.in_ready) begin
        if (model_clip(bus.in_pixel)) begin
          model_disc = (model_disc == 65535) ? 65535 : model_disc + 1;
        end else begin
          exp_q.push_back(model_write(bus.in_pixel));
        end
      end
      if (bus.mem_req && bus.mem_ready) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h, expected no write", bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", bus.mem_addr, e.addr);
          chk("sb_wdata", bus.mem_wdata, e.wdata);
          chk("sb_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic saph_pixel_t mk_pix(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] r, input logic [15:0] g,
                                         input logic [15:0] b, input logic [15:0] a);
    saph_pixel_t p;
    p.x = x;
    p.y = y;
    p.col[0] = r;
    p.col[1] = g;
    p.col[2] = b;
    p.col[3] = a;
    return p;
  endfunction

  function automatic saph_pixel_t rand_pix(input int w, input int h);
    saph_pixel_t p;
    int xi, yi;
    xi = int'($urandom_range(0, w + 7)) - 4;
    yi = int'($urandom_range(0, h + 7)) - 4;
    p.x = 16'(xi);
    p.y = 16'(yi);
    for (int i = 0; i < 4; i++) begin
      p.col[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    end
    return p;
  endfunction

  // Returns at #1 after the accepting posedge.
  task automatic send1(input saph_pixel_t p);
    bit acc;
    acc = 1'b0;
    bus.in_pixel = p;
    bus.in_trig  = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_trig = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic idle_wait(input string name);
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk(name, busy, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fmt;
    logic [31:0] base;
    logic [15:0] stride, x, y, r, g, b, a;
    bit          disc;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
  } vec_t;

  vec_t vt[10];

  initial begin
    int exp_disc;
    int k;
    int acc_cnt, idx;
    bit acc;

    bus.in_trig   = 1'b0;
    bus.in_pixel  = '0;
    bus.mem_ready = 1'b0;

    vt[0] = '{1'b0, 32'h1000, 16'd64, 16'd3, 16'd2, 16'h0100, 16'h0080, 16'hFFFF, 16'h00FF,
              1'b0, 32'h108C, 32'hFFFF8000, 4'hF};
    vt[1] = '{1'b1, 32'h0, 16'd64, 16'd1, 16'd0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
              1'b0, 32'h0, 32'hFFFFFFFF, 4'hC};
    vt[2] = '{1'b1, 32'h0, 16'd64, 16'd2, 16'd0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
              1'b0, 32'h4, 32'hFFFFFFFF, 4'h3};
    vt[3] = '{1'b0, 32'h0, 16'd64, 16'hFFFF, 16'd0, 16'h0, 16'h0, 16'h0, 16'h0,
              1'b1, 32'h0, 32'h0, 4'h0};
    vt[4] = '{1'b0, 32'h0, 16'd64, 16'd100, 16'd0, 16'h0, 16'h0, 16'h0, 16'h0,
              1'b1, 32'h0, 32'h0, 4'h0};
    vt[5] = '{1'b0, 32'h0, 16'd64, 16'd0, 16'd50, 16'h0, 16'h0, 16'h0, 16'h0,
              1'b1, 32'h0, 32'h0, 4'h0};
    vt[6] = '{1'b1, 32'h2000, 16'd320, 16'd5, 16'd3, 16'h00F8, 16'h00FC, 16'h0008, 16'h0,
              1'b0, 32'h23C8, 32'hFFE1FFE1, 4'hC};
    vt[7] = '{1'b0, 32'h0, 16'd400, 16'd99, 16'd49, 16'h7FFF, 16'h8000, 16'h0012, 16'h0101,
              1'b0, 32'h4E1C, 32'hFFFF0012, 4'hF};
    vt[8] = '{1'b0, 32'hFFFFFFF0, 16'd16, 16'd1, 16'd1, 16'h0001, 16'h00FE, 16'h0100, 16'h0,
              1'b0, 32'h4, 32'h0001FEFF, 4'hF};
    vt[9] = '{1'b0, 32'h100, 16'd4, 16'd0, 16'd0, 16'h0, 16'h0, 16'h0, 16'h0,
              1'b0, 32'h100, 32'h0, 4'hF};

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_discard", 32'(discard_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Table: one pixel per vector, memory stalled until the request is inspected.
    cfg_width  = 16'd100;
    cfg_height = 16'd50;
    exp_disc   = 0;
    for (int i = 0; i < 10; i++) begin
      cfg_fmt    = vt[i].fmt;
      cfg_base   = vt[i].base;
      cfg_stride = vt[i].stride;
      tick();
      send1(mk_pix(vt[i].x, vt[i].y, vt[i].r, vt[i].g, vt[i].b, vt[i].a));
      chk($sformatf("vec%0d_req_at_accept", i), bus.mem_req, 1'b0);
      if (vt[i].disc) begin
        exp_disc++;
        for (int c = 0; c < 6; c++) begin
          tick();
          chk($sformatf("vec%0d_no_req", i), bus.mem_req, 1'b0);
          chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
        end
        chk($sformatf("vec%0d_discard_cnt", i), 32'(discard_cnt), 32'(exp_disc));
      end else begin
        k = 0;
        while (!bus.mem_req && k < 8) begin
          tick();
          k++;
        end
        chk($sformatf("vec%0d_latency", i), k, 2);
        chk($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].addr);
        chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].wdata);
        chk($sformatf("vec%0d_wstrb", i), 32'(bus.mem_wstrb), 32'(vt[i].strb));
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk($sformatf("vec%0d_busy_after", i), busy, 1'b0);
      end
    end
    idle_wait("table_idle");

    // Back-pressure: 10 pixels offered with memory stalled, then released at cycle 14.
    cfg_fmt = 1'b0; cfg_base = 32'h0; cfg_stride = 16'd400;
    tick();
    acc_cnt = 0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 14) begin
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        bus.mem_ready = 1'b1;
      end
      if (idx < 10) begin
        bus.in_trig  = 1'b1;
        bus.in_pixel = mk_pix(16'(idx), 16'd1, 16'(idx * 16), 16'h0040, 16'h0100, 16'h00FF);
      end else begin
        bus.in_trig = 1'b0;
      end
      @(negedge clk);
      acc = bus.in_trig && bus.in_ready;
      if (c >= 14 && c <= 23) chk($sformatf("bp_stream_c%0d", c), bus.mem_req, 1'b1);
      if (c == 24) chk("bp_stream_end", bus.mem_req, 1'b0);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        acc_cnt++;
      end
    end
    bus.in_trig = 1'b0;
    chk("bp_total_accepted", acc_cnt, 10);
    idle_wait("bp_idle");
    chk("bp_queue_empty", exp_q.size(), 0);
    bus.mem_ready = 1'b0;

    // Randomized traffic, configuration changed only while idle.
    for (int blk = 0; blk < 3; blk++) begin
      cfg_fmt    = 1'($urandom_range(0, 1));
      cfg_base   = $urandom & 32'hFFFF_FFFC;
      cfg_stride = 16'($urandom) & 16'hFFFC;
      cfg_width  = 16'($urandom_range(1, 40));
      cfg_height = 16'($urandom_range(1, 40));
      tick();
      for (int c = 0; c < 250; c++) begin
        bus.in_trig   = ($urandom_range(0, 9) < 7);
        bus.in_pixel  = rand_pix(int'(cfg_width), int'(cfg_height));
        bus.mem_ready = ($urandom_range(0, 9) < 6);
        tick();
      end
      bus.in_trig   = 1'b0;
      bus.mem_ready = 1'b1;
      idle_wait($sformatf("rand%0d_idle", blk));
      chk($sformatf("rand%0d_queue_empty", blk), exp_q.size(), 0);
      chk($sformatf("rand%0d_discard_cnt", blk), 32'(discard_cnt), 32'(model_disc));
      bus.mem_ready = 1'b0;
    end

    // Reset with a full FIFO and a pending request.
    cfg_fmt = 1'b0; cfg_base = 32'h8000; cfg_stride = 16'd64;
    cfg_width = 16'd100; cfg_height = 16'd50;
    tick();
    for (int i = 0; i < 4; i++) send1(mk_pix(16'(i), 16'd0, 16'h0010, 16'h0020, 16'h0030, 16'h0040));
    repeat (3) tick();
    chk("rstmid_req_before", bus.mem_req, 1'b1);
    chk("rstmid_in_ready_before", bus.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", bus.mem_req, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_in_ready", bus.in_ready, 1'b1);
    chk("rstmid_discard", 32'(discard_cnt), 32'h0);
    exp_q.delete();
    model_disc = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (10) tick();
    chk("rstpost_req", bus.mem_req, 1'b0);
    chk("rstpost_busy", busy, 1'b0);
    chk("rstpost_in_ready", bus.in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/saph_pixel_writer.md
# saph_pixel_writer

Pixel write stage directly downstream of `saph_trz_rasterizer`: accepts rasterized pixels on the same trig/ready handshake, clips them against the framebuffer rectangle, converts 8.8 fixed-point vertex colour to the framebuffer format, computes the byte address, and issues single-beat writes to the memory arbiter. A small FIFO decouples rasterizer throughput from memory stalls.

## Interface
- `fifo_depth`, 4: write FIFO entries; power of two, ≥2.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_trig` in 1: pixel valid; connects to rasterizer `out_trig`.
- `in_pixel` in `pixel`: connects to rasterizer `out_pixel`. Fields used: `x`, `y` (signed 16), `col[4]` (r, g, b, a; signed 8.8).
- `in_ready` out 1: will accept a pixel at the next posedge; connects to rasterizer `out_ready`.
- `cfg_base` in 32: framebuffer byte base; 4-byte aligned.
- `cfg_stride` in 16: row pitch in bytes; multiple of 4.
- `cfg_width`, `cfg_height` in 16: clip bounds, unsigned.
- `cfg_fmt` in 1: 0 = ARGB8888 (4 B/px), 1 = RGB565 (2 B/px).
- `mem_req` out 1: write request valid.
- `mem_addr` out 32: word-aligned byte address (`[1:0]` = 0).
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: byte enables.
- `mem_ready` in 1: arbiter accepts the request at this posedge.
- `busy` out 1: any pixel in the pipeline or FIFO.
- `discard_cnt` out 16: clipped-pixel count, saturating.

## Operation
- Accept: `in_trig && in_ready` at posedge.
- S1 (clip + colour): discard if `x<0`, `y<0`, `x>=cfg_width` or `y>=cfg_height`; discard increments `discard_cnt` (saturates at 0xFFFF) and frees its slot.
- Channel convert: 8.8 value v → 8-bit c: v<0 → 0; v≥0x0100 → 0xFF; else `v[7:0]`.
- ARGB8888: data = {a,r,g,b}. RGB565: {r[7:3], g[7:2], b[7:3]}.
- S2 (address): `byte = cfg_base + y*cfg_stride + x*bpp`, 32-bit modulo arithmetic, 16×16 unsigned multiply. `mem_addr = {byte[31:2], 2'b00}`.
- Strobes: 8888 → 1111. 565 → 0011 if `byte[1]`=0, else 1100; the 16-bit value is replicated in both halves of `mem_wdata`.
- S2 result is written to the FIFO. FIFO head drives `mem_*`; pop on `mem_req && mem_ready`.
- Credit flow control: `in_ready = (S1 valid + S2 valid + FIFO count) < fifo_depth`. Combinational from registered state only; it must never depend on `in_trig`.
- `busy` = S1 valid | S2 valid | FIFO non-empty.
- The `cfg_*` inputs must be changed only while `busy`=0; behaviour is undefined otherwise.
- No reordering: memory writes are issued in acceptance order.

## Timing
- Reset values: `in_ready`=1 (occupancy 0), `mem_req`=0, `mem_addr`/`mem_wdata`/`mem_wstrb`=0, `busy`=0, `discard_cnt`=0.
- Reset asserted mid-operation: all stages and the FIFO are flushed immediately and `mem_req` drops asynchronously. In-flight pixels are lost.
- Latency: a pixel accepted at posedge N is written to the FIFO at N+2; `mem_req` is high in the cycle after N+2 (minimum 3 cycles to request).
- Throughput: 1 pixel/cycle while `mem_ready` is held high.
- FIFO full and `mem_ready`=0: `in_ready`=0; S1/S2 never overflow because of the credit rule.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Simultaneous push and pop on an empty FIFO: the head is valid the next cycle; there is no bypass.
- `mem_*` must hold stable while `mem_req`=1 and `mem_ready`=0.

## Structure
- `pixel` and `vertex` typedefs already live in `saph_defines.svh`.
- Add the fb format enum (`SAPH_FB_ARGB8888`, `SAPH_FB_RGB565`) and a `saph_fb_wr` struct {addr, wdata, wstrb} to the shared package.
- Sub-module: `saph_fifo`, a generic synchronous FIFO parameterised by type and depth, with count output; reusable elsewhere.
- The colour saturate/pack logic is a package function, not a module.

## Test plan
- Reset, then a single pixel (x=3, y=2, col r=0x0100, g=0x0080, b=−1, a=0x00FF), ARGB8888, base 0x1000, stride 64 → `mem_addr`=0x108C, `wdata`=0xFFFF8000, `wstrb`=1111, `mem_req` 3 cycles after accept.
- RGB565 with x=1 and x=2 on y=0, base 0, all channels 0x00FF → addr 0x0 strobe 1100, then addr 0x4 strobe 0011; both with `wdata`=0xFFFFFFFF.
- Pixels at x=−1, x=`cfg_width`, y=`cfg_height` → no `mem_req`, `discard_cnt`=3, `in_ready` stays 1.
- `mem_ready`=0 while 10 pixels are offered back-to-back → exactly 4 accepted, `in_ready`=0. Release `mem_ready` → 4 writes in order, then remaining pixels flow at 1/cycle.
- Assert `rst` low with a full FIFO and `mem_req`=1 → `mem_req`=0 immediately, `busy`=0, `in_ready`=1 after release; no stale writes issued.
